// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared types and constants for the instruction-memory arbiter
package imem_arb_pkg;
  localparam int IMEM_WORD_W = 32;
  typedef enum logic [1:0] {ST_RUN, ST_LOCKED, ST_DRAIN} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LD} owner_e;
endpackage

// File: rtl/imem_addr_chk.sv
// imem_addr_chk: flags misaligned or out-of-range byte addresses and extracts the word index
module imem_addr_chk
  import imem_arb_pkg::*;
#(
  parameter int MEM_AW = 8
) (
  input  logic [IMEM_WORD_W-1:0] i_addr,
  output logic                   o_bad,
  output logic [MEM_AW-1:0]      o_idx
);
  assign o_bad = (i_addr[1:0] != 2'b00) || ((i_addr >> (MEM_AW + 2)) != '0);
  assign o_idx = i_addr[MEM_AW+1:2];
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one synchronous instruction RAM between fetch and loader ports; define IMEM_ARB_RR_EN for round-robin arbitration
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int MEM_AW = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_req_valid,
  input  logic [IMEM_WORD_W-1:0] if_req_addr,
  output logic                   if_req_ready,
  input  logic                   if_flush,
  output logic                   if_rsp_valid,
  output logic [IMEM_WORD_W-1:0] if_rsp_data,
  output logic                   if_rsp_err,
  input  logic                   ld_req_valid,
  input  logic                   ld_req_we,
  input  logic [IMEM_WORD_W-1:0] ld_req_addr,
  input  logic [IMEM_WORD_W-1:0] ld_req_wdata,
  output logic                   ld_req_ready,
  input  logic                   ld_lock,
  output logic                   ld_rsp_valid,
  output logic [IMEM_WORD_W-1:0] ld_rsp_data,
  output logic                   ld_rsp_err,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [MEM_AW-1:0]      mem_addr,
  output logic [IMEM_WORD_W-1:0] mem_wdata,
  input  logic [IMEM_WORD_W-1:0] mem_rdata,
  output logic                   locked
);
  logic              w_if_bad, w_ld_bad, w_ld_win;
  logic [MEM_AW-1:0] w_if_idx, w_ld_idx;
  state_e            r_state;
  owner_e            r_own;
  logic              r_err, r_wr, r_locked;

  imem_addr_chk #(.MEM_AW(MEM_AW)) u_if_chk (.i_addr(if_req_addr), .o_bad(w_if_bad), .o_idx(w_if_idx));
  imem_addr_chk #(.MEM_AW(MEM_AW)) u_ld_chk (.i_addr(ld_req_addr), .o_bad(w_ld_bad), .o_idx(w_ld_idx));

`ifdef IMEM_ARB_RR_EN
  logic r_rr_ld;
  assign w_ld_win = r_rr_ld;
  // pointer flips on every RUN conflict so the loser wins the next one
  always_ff @(posedge clk or posedge reset)
    if (reset) r_rr_ld <= 1'b1;
    else if (r_state == ST_RUN && if_req_valid && ld_req_valid) r_rr_ld <= !r_rr_ld;
`else
  assign w_ld_win = 1'b1;
`endif

  assign ld_req_ready = !reset && ld_req_valid &&
                        (r_state == ST_LOCKED || (r_state == ST_RUN && (!if_req_valid || w_ld_win)));
  assign if_req_ready = !reset && if_req_valid && r_state == ST_RUN && !(ld_req_valid && w_ld_win);

  assign mem_en    = (ld_req_ready && !w_ld_bad) || (if_req_ready && !w_if_bad);
  assign mem_we    = ld_req_ready && !w_ld_bad && ld_req_we;
  assign mem_addr  = ld_req_ready ? w_ld_idx : w_if_idx;
  assign mem_wdata = ld_req_ready ? ld_req_wdata : '0;

  // remember owner and kind of the single outstanding access for next-cycle response
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_own <= OWN_NONE;
      r_err <= 1'b0;
      r_wr  <= 1'b0;
    end else begin
      r_own <= ld_req_ready ? OWN_LD : if_req_ready ? OWN_IF : OWN_NONE;
      r_err <= ld_req_ready ? w_ld_bad : w_if_bad;
      r_wr  <= ld_req_ready && ld_req_we;
    end

  assign if_rsp_valid = r_own == OWN_IF && !if_flush;
  assign if_rsp_data  = (if_rsp_valid && !r_err) ? mem_rdata : '0;
  assign if_rsp_err   = if_rsp_valid && r_err;
  assign ld_rsp_valid = r_own == OWN_LD;
  assign ld_rsp_data  = (ld_rsp_valid && !r_err && !r_wr) ? mem_rdata : '0;
  assign ld_rsp_err   = ld_rsp_valid && r_err;

  // ownership FSM; DRAIN grants nothing, so one cycle there empties the pipeline
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state  <= ST_RUN;
      r_locked <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN:    if (ld_lock) begin r_state <= ST_LOCKED; r_locked <= 1'b1; end
        ST_LOCKED: if (!ld_lock) begin r_state <= ST_DRAIN; r_locked <= 1'b0; end
        default:   begin r_state <= ST_RUN; r_locked <= 1'b0; end
      endcase
    end

  assign locked = r_locked;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed stimulus with a response scoreboard for imem_arbiter
module tb_imem_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        if_req_valid = 1'b0, if_flush = 1'b0, ld_req_valid = 1'b0, ld_req_we = 1'b0, ld_lock = 1'b0;
  logic [31:0] if_req_addr = '0, ld_req_addr = '0, ld_req_wdata = '0;
  logic        if_req_ready, if_rsp_valid, if_rsp_err, ld_req_ready, ld_rsp_valid, ld_rsp_err;
  logic        mem_en, mem_we, locked;
  logic [31:0] if_rsp_data, ld_rsp_data, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] ram [0:255];
  int          n_chk = 0, n_fail = 0;
  logic        g;

  typedef struct packed {logic ld; logic err; logic [31:0] data;} rsp_t;
  rsp_t q[$];

  imem_arbiter #(.MEM_AW(8)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .ld_req_valid(ld_req_valid), .ld_req_we(ld_req_we), .ld_req_addr(ld_req_addr),
    .ld_req_wdata(ld_req_wdata), .ld_req_ready(ld_req_ready), .ld_lock(ld_lock),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data), .ld_rsp_err(ld_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .locked(locked)
  );

  always #5 clk = ~clk;

  // RAM model: word i preloads to 0xA500_0000|i, word 4 holds addi x1,x0,5
  always @(posedge clk)
    if (reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'hA500_0000 | i;
      ram[4] <= 32'h0050_0093;
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_rsp(input logic ld, input logic err, input logic [31:0] d);
    q.push_back({ld, err, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // monitor: every response strobe must match the oldest expected response
  always @(negedge clk)
    if (!reset && (if_rsp_valid || ld_rsp_valid)) begin
      rsp_t e;
      if (q.size() == 0) chk("unexpected_rsp", {ld_rsp_valid, if_rsp_valid}, 64'd0);
      else begin
        e = q.pop_front();
        chk("rsp", {ld_rsp_valid, if_rsp_valid, ld_rsp_valid ? ld_rsp_err : if_rsp_err,
                    ld_rsp_valid ? ld_rsp_data : if_rsp_data},
                   {e.ld, !e.ld, e.err, e.data});
      end
    end

  initial begin
    step(); step(); settle();
    chk("rst_if_rsp", {if_rsp_valid, if_rsp_err, if_rsp_data}, 64'd0);
    chk("rst_ld_rsp", {ld_rsp_valid, ld_rsp_err, ld_rsp_data}, 64'd0);
    chk("rst_ctrl", {locked, mem_en, mem_we}, 64'd0);
    step(); reset = 1'b0;
    // single fetch
    step(); if_req_valid = 1'b1; if_req_addr = 32'h10; settle();
    chk("fetch_mem", {if_req_ready, mem_en, mem_we, mem_addr}, {3'b110, 8'd4});
    exp_rsp(1'b0, 1'b0, 32'h0050_0093);
    // conflict for 4 cycles
    step(); ld_req_valid = 1'b1; ld_req_addr = 32'h20; if_req_addr = 32'h30;
    for (int i = 0; i < 4; i++) begin
      settle();
`ifdef IMEM_ARB_RR_EN
      g = (i % 2 == 0);
`else
      g = 1'b1;
`endif
      chk("conflict_grant", {ld_req_ready, if_req_ready, mem_addr}, {g, !g, g ? 8'd8 : 8'd12});
      exp_rsp(g, 1'b0, g ? 32'hA500_0008 : 32'hA500_000C);
      step();
    end
    ld_req_valid = 1'b0;
    // bad and boundary addresses
    if_req_addr = 32'h402; settle();
    chk("bad_misalign", {if_req_ready, mem_en}, 2'b10);
    exp_rsp(1'b0, 1'b1, 32'h0);
    step(); if_req_addr = 32'h400; settle();
    chk("bad_range", {if_req_ready, mem_en}, 2'b10);
    exp_rsp(1'b0, 1'b1, 32'h0);
    step(); if_req_addr = 32'h3FC; settle();
    chk("max_addr", {if_req_ready, mem_en, mem_addr}, {2'b11, 8'hFF});
    exp_rsp(1'b0, 1'b0, 32'hA500_00FF);
    step(); if_req_valid = 1'b0; ld_req_valid = 1'b1; ld_req_we = 1'b1; ld_req_addr = 32'h9; settle();
    chk("bad_ld_write", {ld_req_ready, mem_en, mem_we}, 3'b100);
    exp_rsp(1'b1, 1'b1, 32'h0);
    // lock, write, read back, unlock
    step(); ld_req_valid = 1'b0; ld_lock = 1'b1; settle();
    chk("lock_pending", locked, 1'b0);
    step(); if_req_valid = 1'b1; if_req_addr = 32'h10;
    ld_req_valid = 1'b1; ld_req_addr = 32'h8; ld_req_wdata = 32'hDEADBEEF; settle();
    chk("locked", locked, 1'b1);
    chk("lock_write", {ld_req_ready, if_req_ready, mem_en, mem_we, mem_addr, mem_wdata},
        {4'b1011, 8'd2, 32'hDEADBEEF});
    exp_rsp(1'b1, 1'b0, 32'h0);
    step(); ld_req_we = 1'b0; ld_lock = 1'b0; settle();
    chk("lock_read", {ld_req_ready, if_req_ready, mem_en, mem_we, mem_addr}, {4'b1010, 8'd2});
    exp_rsp(1'b1, 1'b0, 32'hDEADBEEF);
    step(); settle();
    chk("drain", {locked, ld_req_ready, if_req_ready, mem_en}, 4'b0000);
    ld_req_valid = 1'b0;
    step(); settle();
    chk("run_again", {if_req_ready, mem_addr}, {1'b1, 8'd4});
    exp_rsp(1'b0, 1'b0, 32'h0050_0093);
    // flush: first fetch discarded, fetch in the flush cycle responds
    step(); settle();
    chk("flush_acc0", if_req_ready, 1'b1);
    step(); if_flush = 1'b1; if_req_addr = 32'h14; settle();
    chk("flush_suppress", if_rsp_valid, 1'b0);
    chk("flush_acc1", {if_req_ready, mem_addr}, {1'b1, 8'd5});
    exp_rsp(1'b0, 1'b0, 32'hA500_0005);
    step(); if_flush = 1'b0; if_req_addr = 32'h10; settle();
    chk("pre_reset_acc", if_req_ready, 1'b1);
    // reset mid-flight drops the outstanding fetch
    step(); reset = 1'b1; if_req_valid = 1'b0; settle();
    chk("reset_outputs", {if_rsp_valid, if_rsp_data, ld_rsp_valid, locked, mem_en}, 64'd0);
    step(); reset = 1'b0; settle();
    chk("post_reset_quiet", {if_rsp_valid, ld_rsp_valid}, 2'b00);
    step(); if_req_valid = 1'b1; if_req_addr = 32'h14; settle();
    chk("post_reset_run", {locked, if_req_ready}, 2'b01);
    exp_rsp(1'b0, 1'b0, 32'hA500_0005);
    step(); if_req_valid = 1'b0;
    step(); step();
    chk("sb_empty", q.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
